// File: rtl/seq_detect_param.sv
// seq_detect_param: parameterised serial pattern detector with a Mealy match flag.
//
// Bits are accepted when i_valid=1 and load=0. Accepted bits shift into a
// (PAT_W-1)-bit history, newest bit in the LSB. o fires in the same cycle as
// the final pattern bit. A saturating counter tallies matches. In
// non-overlapping mode the history is cleared after a match.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   i          in   serial data bit
//   i_valid    in   qualifies i
//   overlap    in   1 = overlapping detection, 0 = restart after each match
//   load       in   strobe: pat_in replaces the active pattern and history is cleared
//   pat_in     in   new pattern, MSB is the first bit in time
//   cnt_clr    in   synchronous clear of match_cnt (wins over increment)
//   o          out  combinational match flag
//   match_cnt  out  saturating match count
//   armed      out  history holds PAT_W-1 valid bits (register-derived)
module seq_detect_param #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic             i_valid,
  input  logic             overlap,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             o,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int unsigned      FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             full;
  logic             match;
  logic [PAT_W-1:0] window;

  // rst is folded into accept so o is forced low while reset is held.
  assign accept = i_valid & ~load & ~rst;
  assign full   = (fill_q == FILL_MAX);
  assign window = {hist_q, i};
  assign match  = accept & full & (window == pat_q);

  assign o         = match;
  assign match_cnt = cnt_q;
  assign armed     = full;

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;

    if (load) begin
      // The bit presented alongside load is discarded.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      if (match && !overlap) begin
        // Non-overlapping: the matching bit does not seed the next window.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        if (!full) begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  typedef struct {
    logic       rst;
    logic       v;
    logic       b;
    logic       ovl;
    logic       ld;
    logic [3:0] pat;
    logic       clr;
    logic       eo;
    logic       ea;
    logic [1:0] ec;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i;
  logic       i_valid;
  logic       overlap;
  logic       load;
  logic [3:0] pat_in;
  logic       cnt_clr;
  logic       o;
  logic [1:0] match_cnt;
  logic       armed;

  int checks   = 0;
  int failures = 0;

  step_t exp_q[$];

  always #5 clk = ~clk;

  seq_detect_param #(
    .PAT_W  (4),
    .PAT_RST(4'b1101),
    .CNT_W  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i        (i),
    .i_valid  (i_valid),
    .overlap  (overlap),
    .load     (load),
    .pat_in   (pat_in),
    .cnt_clr  (cnt_clr),
    .o        (o),
    .match_cnt(match_cnt),
    .armed    (armed)
  );

  function automatic step_t mk(input logic r, input logic v, input logic b, input logic ov,
                               input logic ld, input logic [3:0] p, input logic cl,
                               input logic eo, input logic ea, input logic [1:0] ec);
    step_t s;
    s.rst = r; s.v = v; s.b = b; s.ovl = ov; s.ld = ld; s.pat = p; s.clr = cl;
    s.eo = eo; s.ea = ea; s.ec = ec;
    return s;
  endfunction

  // Drive one cycle of stimulus and post its expected outcome.
  task automatic drive(input step_t s);
    rst     = s.rst;
    i_valid = s.v;
    i       = s.b;
    overlap = s.ovl;
    load    = s.ld;
    pat_in  = s.pat;
    cnt_clr = s.clr;
    exp_q.push_back(s);
  endtask

  task automatic test_reset();
    step_t st[$];
    step_t e;
    st.push_back(mk(1, 1, 1, 1, 1, 4'b0110, 1, 0, 0, 2'd0));
    st.push_back(mk(1, 1, 1, 0, 1, 4'b0110, 0, 0, 0, 2'd0));
    foreach (st[k]) begin
      drive(st[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (o !== e.eo) begin failures++; $display("FAIL reset[%0d] o got=%b exp=%b", k, o, e.eo); end
      @(posedge clk); #1;
      checks++;
      if (armed !== e.ea) begin failures++; $display("FAIL reset[%0d] armed got=%b exp=%b", k, armed, e.ea); end
      checks++;
      if (match_cnt !== e.ec) begin failures++; $display("FAIL reset[%0d] cnt got=%0d exp=%0d", k, match_cnt, e.ec); end
    end
  endtask

  task automatic test_overlap();
    step_t st[$];
    step_t e;
    logic [6:0] b  = 7'b1101101;
    logic [6:0] eo = 7'b0001001;
    logic [6:0] ea = 7'b0011111;
    logic [1:0] ec [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    st.push_back(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    for (int k = 0; k < 7; k++) st.push_back(mk(0, 1, b[6-k], 1, 0, 4'h0, 0, eo[6-k], ea[6-k], ec[k]));
    foreach (st[k]) begin
      drive(st[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (o !== e.eo) begin failures++; $display("FAIL overlap[%0d] o got=%b exp=%b", k, o, e.eo); end
      @(posedge clk); #1;
      checks++;
      if (armed !== e.ea) begin failures++; $display("FAIL overlap[%0d] armed got=%b exp=%b", k, armed, e.ea); end
      checks++;
      if (match_cnt !== e.ec) begin failures++; $display("FAIL overlap[%0d] cnt got=%0d exp=%0d", k, match_cnt, e.ec); end
    end
  endtask

  task automatic test_nonoverlap();
    step_t st[$];
    step_t e;
    logic [6:0] b  = 7'b1101101;
    logic [6:0] eo = 7'b0001000;
    logic [6:0] ea = 7'b0010001;
    logic [1:0] ec [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    st.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 2'd0));
    for (int k = 0; k < 7; k++) st.push_back(mk(0, 1, b[6-k], 0, 0, 4'h0, 0, eo[6-k], ea[6-k], ec[k]));
    foreach (st[k]) begin
      drive(st[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (o !== e.eo) begin failures++; $display("FAIL nonoverlap[%0d] o got=%b exp=%b", k, o, e.eo); end
      @(posedge clk); #1;
      checks++;
      if (armed !== e.ea) begin failures++; $display("FAIL nonoverlap[%0d] armed got=%b exp=%b", k, armed, e.ea); end
      checks++;
      if (match_cnt !== e.ec) begin failures++; $display("FAIL nonoverlap[%0d] cnt got=%0d exp=%0d", k, match_cnt, e.ec); end
    end
  endtask

  task automatic test_stall();
    step_t st[$];
    step_t e;
    // Stall cycles present i=1 so a stall that leaks into history breaks the match.
    logic [6:0] b  = 7'b1111101;
    logic [6:0] v  = 7'b1100011;
    logic [6:0] eo = 7'b0000001;
    logic [6:0] ea = 7'b0000011;
    st.push_back(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    for (int k = 0; k < 7; k++) st.push_back(mk(0, v[6-k], b[6-k], 1, 0, 4'h0, 0, eo[6-k], ea[6-k], (k == 6) ? 2'd1 : 2'd0));
    foreach (st[k]) begin
      drive(st[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (o !== e.eo) begin failures++; $display("FAIL stall[%0d] o got=%b exp=%b", k, o, e.eo); end
      @(posedge clk); #1;
      checks++;
      if (armed !== e.ea) begin failures++; $display("FAIL stall[%0d] armed got=%b exp=%b", k, armed, e.ea); end
      checks++;
      if (match_cnt !== e.ec) begin failures++; $display("FAIL stall[%0d] cnt got=%0d exp=%0d", k, match_cnt, e.ec); end
    end
  endtask

  task automatic test_load();
    step_t st[$];
    step_t e;
    st.push_back(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 1, 2'd0));
    // History is 110 and i=1 would complete 1101; load must suppress it.
    st.push_back(mk(0, 1, 1, 1, 1, 4'b0110, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 1, 2'd0));
    st.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 1, 1, 2'd1));
    st.push_back(mk(0, 0, 0, 1, 1, 4'b1101, 0, 0, 0, 2'd1));
    foreach (st[k]) begin
      drive(st[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (o !== e.eo) begin failures++; $display("FAIL load[%0d] o got=%b exp=%b", k, o, e.eo); end
      @(posedge clk); #1;
      checks++;
      if (armed !== e.ea) begin failures++; $display("FAIL load[%0d] armed got=%b exp=%b", k, armed, e.ea); end
      checks++;
      if (match_cnt !== e.ec) begin failures++; $display("FAIL load[%0d] cnt got=%0d exp=%0d", k, match_cnt, e.ec); end
    end
  endtask

  task automatic test_saturate();
    step_t st[$];
    step_t e;
    int    cnt = 0;
    logic  bit_v, m, clr;
    // 1101 then 101 repeated; matches land on every third bit from index 3.
    st.push_back(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    for (int k = 0; k < 22; k++) begin
      if (k < 4) bit_v = (k != 2);
      else       bit_v = ((k - 4) % 3 != 1);
      m   = (k >= 3) && (k % 3 == 0);
      clr = (k == 18);
      if (clr)                cnt = 0;
      else if (m && cnt < 3)  cnt = cnt + 1;
      st.push_back(mk(0, 1, bit_v, 1, 0, 4'h0, clr, m, (k >= 2), 2'(cnt)));
    end
    foreach (st[k]) begin
      drive(st[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (o !== e.eo) begin failures++; $display("FAIL saturate[%0d] o got=%b exp=%b", k, o, e.eo); end
      @(posedge clk); #1;
      checks++;
      if (armed !== e.ea) begin failures++; $display("FAIL saturate[%0d] armed got=%b exp=%b", k, armed, e.ea); end
      checks++;
      if (match_cnt !== e.ec) begin failures++; $display("FAIL saturate[%0d] cnt got=%0d exp=%0d", k, match_cnt, e.ec); end
    end
  endtask

  task automatic test_rst_mid();
    step_t st[$];
    step_t e;
    st.push_back(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 1, 2'd0));
    // i=1 under reset would complete 1101 from the stale history.
    st.push_back(mk(1, 1, 1, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 2'd0));
    st.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 1, 2'd0));
    st.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 1, 1, 2'd1));
    foreach (st[k]) begin
      drive(st[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (o !== e.eo) begin failures++; $display("FAIL rst_mid[%0d] o got=%b exp=%b", k, o, e.eo); end
      @(posedge clk); #1;
      checks++;
      if (armed !== e.ea) begin failures++; $display("FAIL rst_mid[%0d] armed got=%b exp=%b", k, armed, e.ea); end
      checks++;
      if (match_cnt !== e.ec) begin failures++; $display("FAIL rst_mid[%0d] cnt got=%0d exp=%0d", k, match_cnt, e.ec); end
    end
  endtask

  initial begin
    rst     = 1'b1;
    i       = 1'b0;
    i_valid = 1'b0;
    overlap = 1'b1;
    load    = 1'b0;
    pat_in  = 4'h0;
    cnt_clr = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_stall();
    test_load();
    test_saturate();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
